// File: rtl/dec_arb_pkg.sv
// Shared types and sizes for the round-robin arbiter with forced release.
// The round-robin winner search lives here so the top stays focused on sequencing.
package dec_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // First set bit of r, searching upward from last+1. The 3-bit add wraps mod 8.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             hit;
    pick = last;
    hit  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last + IDX_W'(i);
      if (!hit && r[cand]) begin
        pick = cand;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder; en low forces all-zero.
// Combinational, no backpressure.
module dec3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  assign onehot = en ? (8'b1 << idx) : 8'b0;

endmodule

// File: rtl/dec_arbiter.sv
// Round-robin arbiter over 8 requesters with a forced release after MAX_HOLD cycles.
// Latency: req in IDLE -> gnt next cycle; no backpressure, grant lasts until done/req drop/timeout.
module dec_arbiter
  import dec_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int NUM_REQ  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   last_idx, last_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic               valid_nxt;
  logic               tmo_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic               rel_normal;

  // Only the current owner's done/req bits can end a grant.
  assign rel_normal = done[gnt_idx] | ~req[gnt_idx];

  always_comb begin
    state_nxt = state;
    idx_nxt   = gnt_idx;
    last_nxt  = last_idx;
    hold_nxt  = hold_cnt;
    valid_nxt = 1'b0;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          idx_nxt   = rr_pick(req, last_idx);
          last_nxt  = idx_nxt;
          hold_nxt  = '0;
          valid_nxt = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (rel_normal) begin
          state_nxt = GAP;
        end else if (hold_cnt == HOLD_LIM) begin
          state_nxt = GAP;
          tmo_nxt   = 1'b1;
        end else begin
          hold_nxt  = hold_cnt + HOLD_W'(1);
          valid_nxt = 1'b1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  dec3to8 u_dec (
    .idx    (idx_nxt),
    .en     (valid_nxt),
    .onehot (gnt_nxt)
  );

  // last_idx resets to 7 so the first search after reset starts at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      last_idx  <= '1;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt_idx   <= idx_nxt;
      last_idx  <= last_nxt;
      hold_cnt  <= hold_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_dec_arbiter.sv
// Directed and randomized checks of dec_arbiter against a cycle-level ownership model.
module tb_dec_arbiter;

  localparam int MH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] done = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Model: who owns the grant (-1 none), cycles already held, pending gap, last winner.
  int m_owner, m_held, m_last, m_idx;
  bit m_in_gap, m_tmo;

  always #5 clk = ~clk;

  dec_arbiter #(.MAX_HOLD(MH), .NUM_REQ(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_held   = 0;
    m_last   = 7;
    m_idx    = 0;
    m_in_gap = 1'b0;
    m_tmo    = 1'b0;
  endtask

  task automatic model_step();
    m_tmo = 1'b0;
    if (m_in_gap) begin
      m_in_gap = 1'b0;
    end else if (m_owner >= 0) begin
      if (done[m_owner] || !req[m_owner]) begin
        m_owner  = -1;
        m_in_gap = 1'b1;
      end else if (m_held + 1 == MH) begin
        m_owner  = -1;
        m_in_gap = 1'b1;
        m_tmo    = 1'b1;
      end else begin
        m_held++;
      end
    end else if (req != 8'h00) begin
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (m_last + k) % 8;
        if (req[c]) begin
          m_owner = c;
          m_last  = c;
          m_idx   = c;
          m_held  = 0;
          break;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] e_gnt;
    e_gnt = 8'h00;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    chk({tag, "/gnt"},       gnt,                   e_gnt);
    chk({tag, "/gnt_valid"}, 8'(gnt_valid),         8'(m_owner >= 0));
    chk({tag, "/gnt_idx"},   8'(gnt_idx),           8'(m_idx));
    chk({tag, "/timeout"},   8'(timeout),           8'(m_tmo));
    chk({tag, "/onehot"},    8'($countones(gnt) <= 1), 8'd1);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int nv, nt, got_n;
    logic prev_v;
    logic [7:0] got[$];

    // Power-on reset
    model_reset();
    do_reset();

    // Single requester: timeout after MH grant cycles, gap, idle, re-grant
    req = 8'h04;
    tick("r029");
    chk("r029_first_gnt", gnt, 8'h04);
    chk("r029_first_idx", 8'(gnt_idx), 8'd2);
    nv = 1;
    nt = 0;
    for (int i = 0; i < MH; i++) begin
      tick("r029h");
      nv += int'(gnt_valid);
      nt += int'(timeout);
    end
    chk("r029_grant_len", 8'(nv), 8'(MH));
    chk("r029_tmo_count", 8'(nt), 8'd1);
    chk("r029_tmo_at_gap", 8'(timeout), 8'd1);
    tick("r029i");
    chk("r029_idle_valid", 8'(gnt_valid), 8'd0);
    tick("r029g");
    chk("r029_regrant_idx", 8'(gnt_idx), 8'd2);
    chk("r029_regrant_vld", 8'(gnt_valid), 8'd1);

    // All requesting, done on each grant's 2nd cycle: strict rotation
    do_reset();
    req = 8'hFF;
    done = 8'h00;
    prev_v = 1'b0;
    for (int t = 0; t < 60 && got.size() < 9; t++) begin
      tick("r030");
      if (gnt_valid && !prev_v) got.push_back(8'(gnt_idx));
      prev_v = gnt_valid;
      done = 8'h00;
      if (m_owner >= 0 && m_held == 1) done[m_owner] = 1'b1;
    end
    done = 8'h00;
    got_n = got.size();
    chk("r030_grants", 8'(got_n), 8'd9);
    for (int i = 0; i < 9; i++)
      chk("r030_order", (i < got_n) ? got[i] : 8'hEE, 8'(i % 8));

    // Wrap-around from last_idx=5
    do_reset();
    req = 8'h20;
    tick("r031a");
    chk("r031_setup_idx", 8'(gnt_idx), 8'd5);
    req = 8'h00;
    tick("r031b");
    tick("r031c");
    req = 8'h21;
    tick("r031d");
    chk("r031_wrap_idx", 8'(gnt_idx), 8'd0);
    done = 8'h01;
    tick("r031e");
    done = 8'h00;
    tick("r031f");
    tick("r031g");
    chk("r031_next_idx", 8'(gnt_idx), 8'd5);
    chk("r031_next_vld", 8'(gnt_valid), 8'd1);

    // Non-owner done ignored; owner req drop releases without timeout
    do_reset();
    req = 8'h08;
    tick("r032a");
    done = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick("r032b");
      chk("r032_hold_vld", 8'(gnt_valid), 8'd1);
    end
    req = 8'h00;
    tick("r032c");
    chk("r032_rel_vld", 8'(gnt_valid), 8'd0);
    chk("r032_rel_tmo", 8'(timeout), 8'd0);
    done = 8'h00;

    // done on the limit cycle counts as a normal release
    do_reset();
    req = 8'h04;
    tick("r033a");
    for (int i = 0; i < MH - 1; i++) tick("r033b");
    chk("r033_still_vld", 8'(gnt_valid), 8'd1);
    done = 8'h04;
    tick("r033c");
    chk("r033_gap_vld", 8'(gnt_valid), 8'd0);
    chk("r033_gap_tmo", 8'(timeout), 8'd0);
    done = 8'h00;
    req = 8'h00;

    // Asynchronous reset mid-grant, then fresh search from index 0
    do_reset();
    req = 8'h04;
    tick("r034a");
    tick("r034b");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("r034_async_gnt", gnt, 8'h00);
    chk("r034_async_vld", 8'(gnt_valid), 8'd0);
    chk("r034_async_tmo", 8'(timeout), 8'd0);
    chk("r034_async_idx", 8'(gnt_idx), 8'd0);
    #1;
    rst_n = 1'b1;
    req = 8'h81;
    tick("r034c");
    chk("r034_first_idx", 8'(gnt_idx), 8'd0);
    req = 8'h00;

    // Randomized traffic; requests change slowly so timeouts occur
    do_reset();
    for (int t = 0; t < 2500; t++) begin
      if ($urandom_range(0, 19) == 0) req = 8'($urandom & $urandom);
      done = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      tick("rand");
    end
    req = 8'h00;
    done = 8'h00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
